// File: rtl/regfile_pkg.sv
// Shared types and constants for the integer register file and its scoreboard.
// Also holds the read-port mux used by both read ports.
package regfile_pkg;

  localparam int XLEN    = 32;
  localparam int REG_NUM = 32;
  localparam int AW      = 5;

  typedef logic [XLEN-1:0] reg_bus_t;
  typedef logic [AW-1:0]   reg_addr_t;

  localparam reg_addr_t ZeroReg     = 5'd0;
  localparam reg_bus_t  ZeroWord    = 32'h0;
  localparam logic      WriteEnable = 1'b1;
  localparam logic      ReadEnable  = 1'b1;

  // Disabled, x0 or in-reset reads return zero; a completing write bypasses the array.
  function automatic reg_bus_t read_sel(input logic      rst,
                                        input logic      re,
                                        input reg_addr_t addr,
                                        input logic      wr_en,
                                        input reg_addr_t wr_addr,
                                        input reg_bus_t  wr_data,
                                        input reg_bus_t  entry);
    reg_bus_t res;
    res = ZeroWord;
    if (!rst && re == ReadEnable && addr != ZeroReg) begin
      if (wr_en && wr_addr == addr) res = wr_data;
      else                          res = entry;
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// Write-back, decode-read and issue/scoreboard signals of the register file.
// Suffixes are seen from the register file (slave) side.
interface regfile_if;
  import regfile_pkg::*;

  logic      regs_wen_i;
  reg_addr_t rd_addr_i;
  reg_bus_t  rd_data_i;
  logic      rs1_re_i;
  reg_addr_t rs1_addr_i;
  logic      rs2_re_i;
  reg_addr_t rs2_addr_i;
  reg_bus_t  rs1_data_o;
  reg_bus_t  rs2_data_o;
  logic      issue_wen_i;
  reg_addr_t issue_rd_i;
  logic      flush_i;
  logic      rs1_busy_o;
  logic      rs2_busy_o;

  modport master (
    output regs_wen_i, rd_addr_i, rd_data_i,
    output rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i,
    output issue_wen_i, issue_rd_i, flush_i,
    input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o
  );

  modport slave (
    input  regs_wen_i, rd_addr_i, rd_data_i,
    input  rs1_re_i, rs1_addr_i, rs2_re_i, rs2_addr_i,
    input  issue_wen_i, issue_rd_i, flush_i,
    output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o
  );

endinterface

// File: rtl/regfile_sb.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on write-back.
// Busy is masked when the producer completes this cycle, since the bypass supplies the data.
module regfile_sb
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      rstn,
  input  logic      wr_en_i,
  input  reg_addr_t wr_addr_i,
  input  logic      issue_wen_i,
  input  reg_addr_t issue_rd_i,
  input  logic      flush_i,
  input  logic      rs1_re_i,
  input  reg_addr_t rs1_addr_i,
  input  logic      rs2_re_i,
  input  reg_addr_t rs2_addr_i,
  output logic      rs1_busy_o,
  output logic      rs2_busy_o
);

  logic [REG_NUM-1:0] pending_q;
  logic [REG_NUM-1:0] pending_d;

  // Clear before set so a newer producer on the same register stays outstanding.
  always_comb begin
    pending_d = pending_q;
    if (flush_i) begin
      pending_d = '0;
    end else begin
      if (wr_en_i)                                pending_d[wr_addr_i]  = 1'b0;
      if (issue_wen_i && issue_rd_i != ZeroReg)   pending_d[issue_rd_i] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rstn) pending_q <= '0;
    else      pending_q <= pending_d;
  end

  assign rs1_busy_o = !rstn && (rs1_re_i == ReadEnable) && pending_q[rs1_addr_i] &&
                      !(wr_en_i && wr_addr_i == rs1_addr_i);
  assign rs2_busy_o = !rstn && (rs2_re_i == ReadEnable) && pending_q[rs2_addr_i] &&
                      !(wr_en_i && wr_addr_i == rs2_addr_i);

endmodule

// File: rtl/regfile.sv
// Integer register file x0..x31 with two combinational read ports, write bypass
// and a RAW-hazard scoreboard. rstn is an active-high synchronous reset.
module regfile
  import regfile_pkg::*;
(
  input logic     clk,
  input logic     rstn,
  regfile_if.slave rf
);

  reg_bus_t regs_q [REG_NUM];
  reg_bus_t regs_d [REG_NUM];
  logic     wr_en;

  assign wr_en = (rf.regs_wen_i == WriteEnable) && (rf.rd_addr_i != ZeroReg);

  // Entry 0 is held at zero and trims away in synthesis.
  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[rf.rd_addr_i] = rf.rd_data_i;
    regs_d[0] = ZeroWord;
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      for (int i = 0; i < REG_NUM; i++) regs_q[i] <= ZeroWord;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rf.rs1_data_o = read_sel(rstn, rf.rs1_re_i, rf.rs1_addr_i, wr_en,
                                  rf.rd_addr_i, rf.rd_data_i, regs_q[rf.rs1_addr_i]);
  assign rf.rs2_data_o = read_sel(rstn, rf.rs2_re_i, rf.rs2_addr_i, wr_en,
                                  rf.rd_addr_i, rf.rd_data_i, regs_q[rf.rs2_addr_i]);

  regfile_sb u_sb (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en_i     (wr_en),
    .wr_addr_i   (rf.rd_addr_i),
    .issue_wen_i (rf.issue_wen_i),
    .issue_rd_i  (rf.issue_rd_i),
    .flush_i     (rf.flush_i),
    .rs1_re_i    (rf.rs1_re_i),
    .rs1_addr_i  (rf.rs1_addr_i),
    .rs2_re_i    (rf.rs2_re_i),
    .rs2_addr_i  (rf.rs2_addr_i),
    .rs1_busy_o  (rf.rs1_busy_o),
    .rs2_busy_o  (rf.rs2_busy_o)
  );

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: directed scenarios followed by random traffic, all checked
// against an array-based reference model of the architectural registers and pending set.
module tb_regfile;

  logic clk;
  logic rstn;
  regfile_if rf_if();

  regfile dut (
    .clk  (clk),
    .rstn (rstn),
    .rf   (rf_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  bit          m_pend [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic re, input logic [4:0] a);
    if (rstn || !re || a == 0) return 32'h0;
    if (rf_if.regs_wen_i && rf_if.rd_addr_i == a) return rf_if.rd_data_i;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic re, input logic [4:0] a);
    if (rstn || !re || a == 0) return 32'h0;
    if (rf_if.regs_wen_i && rf_if.rd_addr_i == a) return 32'h0;
    return {31'h0, m_pend[a]};
  endfunction

  task automatic drive(input logic rst, input logic wen, input logic [4:0] wa,
                       input logic [31:0] wd, input logic r1e, input logic [4:0] r1a,
                       input logic r2e, input logic [4:0] r2a, input logic iw,
                       input logic [4:0] ird, input logic fl);
    rstn              = rst;
    rf_if.regs_wen_i  = wen;
    rf_if.rd_addr_i   = wa;
    rf_if.rd_data_i   = wd;
    rf_if.rs1_re_i    = r1e;
    rf_if.rs1_addr_i  = r1a;
    rf_if.rs2_re_i    = r2e;
    rf_if.rs2_addr_i  = r2a;
    rf_if.issue_wen_i = iw;
    rf_if.issue_rd_i  = ird;
    rf_if.flush_i     = fl;
    #2;
  endtask

  // Compare against the model, take a clock edge, then advance the model.
  task automatic step();
    check("rs1_data", rf_if.rs1_data_o, exp_data(rf_if.rs1_re_i, rf_if.rs1_addr_i));
    check("rs2_data", rf_if.rs2_data_o, exp_data(rf_if.rs2_re_i, rf_if.rs2_addr_i));
    check("rs1_busy", {31'h0, rf_if.rs1_busy_o}, exp_busy(rf_if.rs1_re_i, rf_if.rs1_addr_i));
    check("rs2_busy", {31'h0, rf_if.rs2_busy_o}, exp_busy(rf_if.rs2_re_i, rf_if.rs2_addr_i));
    @(posedge clk);
    if (rstn) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'h0;
        m_pend[i] = 1'b0;
      end
    end else begin
      if (rf_if.regs_wen_i && rf_if.rd_addr_i != 0) m_regs[rf_if.rd_addr_i] = rf_if.rd_data_i;
      if (rf_if.flush_i) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
        if (rf_if.regs_wen_i && rf_if.rd_addr_i != 0) m_pend[rf_if.rd_addr_i] = 1'b0;
        if (rf_if.issue_wen_i && rf_if.issue_rd_i != 0) m_pend[rf_if.issue_rd_i] = 1'b1;
      end
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = 32'h0;
      m_pend[i] = 1'b0;
    end
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;

    drive(1, 0, 0, 0, 1, 5, 1, 31, 0, 0, 0); step();
    drive(1, 0, 0, 0, 1, 5, 1, 31, 0, 0, 0); step();

    drive(0, 0, 0, 0, 1, 5, 1, 31, 0, 0, 0);
    check("rst_rd1", rf_if.rs1_data_o, 32'h0);
    check("rst_rd2", rf_if.rs2_data_o, 32'h0);
    check("rst_busy", {30'h0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'h0);
    step();

    drive(0, 1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0);
    check("wr_x3", rf_if.rs1_data_o, 32'hDEADBEEF);
    step();
    drive(0, 1, 0, 32'h1234, 1, 0, 1, 0, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    check("wr_x0", rf_if.rs1_data_o | rf_if.rs2_data_o, 32'h0);
    step();

    drive(0, 1, 7, 32'hA5A5A5A5, 1, 7, 1, 7, 0, 0, 0);
    check("byp_rs1", rf_if.rs1_data_o, 32'hA5A5A5A5);
    check("byp_rs2", rf_if.rs2_data_o, 32'hA5A5A5A5);
    step();

    drive(0, 0, 0, 0, 1, 9, 0, 0, 1, 9, 0);
    check("iss_same_cyc", {31'h0, rf_if.rs1_busy_o}, 32'h0);
    step();
    drive(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    check("busy_x9", {31'h0, rf_if.rs1_busy_o}, 32'h1);
    step();
    drive(0, 1, 9, 32'h00000099, 1, 9, 0, 0, 0, 0, 0);
    check("wb_busy_x9", {31'h0, rf_if.rs1_busy_o}, 32'h0);
    check("wb_data_x9", rf_if.rs1_data_o, 32'h00000099);
    step();
    drive(0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0);
    check("clr_x9", {31'h0, rf_if.rs1_busy_o}, 32'h0);
    step();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0); step();
    drive(0, 1, 4, 32'h00000044, 0, 0, 0, 0, 1, 4, 0); step();
    drive(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    check("setwin_busy", {31'h0, rf_if.rs1_busy_o}, 32'h1);
    check("setwin_data", rf_if.rs1_data_o, 32'h00000044);
    step();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0); step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0); step();
    drive(0, 0, 0, 0, 1, 1, 1, 10, 0, 0, 0);
    check("pend_x1_x10", {30'h0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'h3);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 1); step();
    drive(0, 0, 0, 0, 1, 11, 1, 2, 0, 0, 0);
    check("flush_x11_x2", {30'h0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'h0);
    step();
    drive(0, 0, 0, 0, 1, 1, 1, 10, 0, 0, 0);
    check("flush_x1_x10", {30'h0, rf_if.rs1_busy_o, rf_if.rs2_busy_o}, 32'h0);
    step();

    drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 12, 0); step();
    drive(1, 1, 6, 32'h1, 1, 6, 1, 7, 1, 13, 1);
    check("rst_wr_x6", rf_if.rs1_data_o, 32'h0);
    step();
    drive(0, 0, 0, 0, 1, 6, 1, 12, 0, 0, 0);
    check("post_rst_x6", rf_if.rs1_data_o, 32'h0);
    check("post_rst_busy", {31'h0, rf_if.rs2_busy_o}, 32'h0);
    step();

    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 63) == 0),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom(),
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)),
            $urandom_range(0, 15) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
